// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int ADDR_W          = 6;
    localparam int INSTR_W         = 32;
    localparam int INSTR_BYTES     = 4;
    localparam int DEFAULT_LAST_PC = 60;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        END   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO. slot0 is always the head, so after the last pop
// the head output keeps showing the word that was just consumed.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t slot0_reg;
    fetch_entry_t slot1_reg;
    logic [1:0]   count_reg;
    logic         pop_eff;
    logic         push_eff;

    // Guard against popping empty or pushing full (without a pop) from outside.
    always_comb begin
        pop_eff  = pop & (count_reg != 2'd0);
        push_eff = push & ((count_reg != 2'd2) | pop_eff);
    end

    // Shift-style storage: head in slot0, second entry in slot1; flush wins over push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_reg <= '0;
            slot1_reg <= '0;
            count_reg <= 2'd0;
        end else if (flush) begin
            count_reg <= 2'd0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    if (count_reg == 2'd0) slot0_reg <= push_entry;
                    else                   slot1_reg <= push_entry;
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    if (count_reg == 2'd2) slot0_reg <= slot1_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        slot0_reg <= push_entry;
                    end else begin
                        slot0_reg <= slot1_reg;
                        slot1_reg <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign full  = (count_reg == 2'd2);
    assign empty = (count_reg == 2'd0);
    assign head  = slot0_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC, fetch state machine, redirect/fault
// handling, feeding a two-entry prefetch buffer towards decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = fetch_pkg::ADDR_W,
    parameter int INSTR_W  = fetch_pkg::INSTR_W,
    parameter int RESET_PC = 0,
    parameter int LAST_PC  = DEFAULT_LAST_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               end_of_mem,
    output logic               fault
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LAST_PC);
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              eom_reg, eom_next;
    logic              fault_reg, fault_next;

    logic         buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    fetch_entry_t buf_head;
    fetch_entry_t push_entry;

    assign buf_pop    = ~buf_empty & instr_ready;
    assign push_entry = '{pc: pc_reg, instr: imem_instr};

    // State, PC and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= START_ADDR;
            eom_reg   <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            eom_reg   <= eom_next;
            fault_reg <= fault_next;
        end
    end

    // Next state: fault beats redirect, redirect beats push; FAULT ignores everything.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        eom_next   = eom_reg;
        fault_next = fault_reg;
        buf_push   = 1'b0;
        buf_flush  = 1'b0;
        case (state_reg)
            FETCH, END: begin
                if (redirect_valid) begin
                    buf_flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_next = 1'b1;
                        state_next = FAULT;
                    end else begin
                        pc_next    = redirect_pc;
                        state_next = FETCH;
                        eom_next   = 1'b0;
                    end
                end else if (state_reg == FETCH && run && (!buf_full || buf_pop)) begin
                    if (pc_reg > LAST_ADDR) begin
                        // Target beyond the last word: stop without delivering it.
                        state_next = END;
                        eom_next   = 1'b1;
                    end else begin
                        buf_push = 1'b1;
                        if (pc_reg == LAST_ADDR) begin
                            state_next = END;
                            eom_next   = 1'b1;
                        end else begin
                            pc_next = pc_reg + STEP;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    fetch_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .full       (buf_full),
        .empty      (buf_empty),
        .head       (buf_head)
    );

    assign imem_addr   = pc_reg;
    assign instr_valid = ~buf_empty;
    assign instr_out   = buf_head.instr;
    assign instr_pc    = buf_head.pc;
    assign end_of_mem  = eom_reg;
    assign fault       = fault_reg;

endmodule
